// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter: owns the single GPR write port, merging the in-order
// pipeline write-back stream with buffered out-of-order long-latency results.
module gpr_wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STARVE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 pipe_regf,
  input  logic [31:0]                pipe_data,
  input  logic                       lat_valid,
  output logic                       lat_ready,
  input  logic [4:0]                 lat_regf,
  input  logic [31:0]                lat_data,
  output logic [4:0]                 gpr_w_regf,
  output logic [31:0]                gpr_w_data,
  input  logic [4:0]                 q_regf_a,
  input  logic [4:0]                 q_regf_b,
  output logic                       q_busy_a,
  output logic                       q_busy_b,
  output logic                       stall_req,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned AGEW = $clog2(STARVE + 1);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [4:0]      mem_regf [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [AGEW-1:0] age;
  logic [AGEW-1:0] age_next;
  logic [AW:0]     count_next;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [AW-1:0]   off;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (AW + 1)'(DEPTH));
  assign lat_ready = !full;
  // An r0 destination is accepted on the handshake but never stored.
  assign push      = lat_valid && lat_ready && (lat_regf != '0);

  // Write-port selection; a pipe write offered while stalling is dropped.
  always_comb begin
    pop        = 1'b0;
    gpr_w_regf = '0;
    gpr_w_data = '0;
    if (!rst) begin
      if (!empty && (stall_req || (pipe_regf == '0))) begin
        pop        = 1'b1;
        gpr_w_regf = mem_regf[rd_ptr[AW-1:0]];
        gpr_w_data = mem_data[rd_ptr[AW-1:0]];
      end else if (!stall_req && (pipe_regf != '0)) begin
        gpr_w_regf = pipe_regf;
        gpr_w_data = pipe_data;
      end
    end
  end

  // Next occupancy and starvation age.
  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    age_next   = age;
    if (empty || pop)
      age_next = '0;
    else if (age != AGEW'(STARVE))
      age_next = age + 1'b1;
  end

  // Pointers, age counter and stall request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      age       <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      age <= age_next;
      if (count_next == '0)
        stall_req <= 1'b0;
      else if (age_next == AGEW'(STARVE))
        stall_req <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_regf[wr_ptr[AW-1:0]] <= lat_regf;
      mem_data[wr_ptr[AW-1:0]] <= lat_data;
    end
  end

  // Hazard query over valid entries (head through tail-1).
  always_comb begin
    q_busy_a = 1'b0;
    q_busy_b = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr[AW-1:0];
      if ({1'b0, off} < count) begin
        if ((q_regf_a != '0) && (mem_regf[i] == q_regf_a)) q_busy_a = 1'b1;
        if ((q_regf_b != '0) && (mem_regf[i] == q_regf_b)) q_busy_b = 1'b1;
      end
    end
  end

  // Upstream must hold off pipe writes while stall_req is high.
  a_no_pipe_while_stalled: assert property (
    @(posedge clk) disable iff (rst) !(stall_req && (pipe_regf != '0)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter against a queue-based reference model.
module tb_gpr_wb_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  pipe_regf = '0;
  logic [31:0] pipe_data = '0;
  logic        lat_valid = 1'b0;
  logic        lat_ready;
  logic [4:0]  lat_regf = '0;
  logic [31:0] lat_data = '0;
  logic [4:0]  gpr_w_regf;
  logic [31:0] gpr_w_data;
  logic [4:0]  q_regf_a = '0;
  logic [4:0]  q_regf_b = '0;
  logic        q_busy_a;
  logic        q_busy_b;
  logic        stall_req;
  logic [2:0]  count;

  gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .pipe_regf(pipe_regf), .pipe_data(pipe_data),
    .lat_valid(lat_valid), .lat_ready(lat_ready),
    .lat_regf(lat_regf), .lat_data(lat_data),
    .gpr_w_regf(gpr_w_regf), .gpr_w_data(gpr_w_data),
    .q_regf_a(q_regf_a), .q_regf_b(q_regf_b),
    .q_busy_a(q_busy_a), .q_busy_b(q_busy_b),
    .stall_req(stall_req), .count(count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of {regf, data}, age and stall flag.
  logic [36:0] mq[$];
  int unsigned m_age  = 0;
  bit          m_stall = 0;

  // Expected and observed values for the cycle just stepped (before its edge).
  logic [4:0]  exp_regf, act_regf;
  logic [31:0] exp_data, act_data;
  logic        exp_ready, act_ready;
  logic [2:0]  exp_count, act_count;
  logic        exp_busy_a, act_busy_a, exp_busy_b, act_busy_b;
  logic        exp_stall, act_stall;

  function automatic bit in_q(input logic [4:0] r);
    foreach (mq[i]) if (mq[i][36:32] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of inputs, snapshot outputs, advance model and clock.
  task automatic step(input logic r, input logic [4:0] pr, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic [4:0] qa, input logic [4:0] qb);
    bit do_pop;
    bit was_empty;
    rst       = r;
    pipe_regf = m_stall ? 5'd0 : pr;
    pipe_data = pd;
    lat_valid = lv;
    lat_regf  = lr;
    lat_data  = ld;
    q_regf_a  = qa;
    q_regf_b  = qb;
    #1;
    act_regf = gpr_w_regf; act_data = gpr_w_data; act_ready = lat_ready;
    act_count = count; act_busy_a = q_busy_a; act_busy_b = q_busy_b;
    act_stall = stall_req;

    exp_count  = 3'(mq.size());
    exp_ready  = (mq.size() < DEPTH);
    exp_stall  = m_stall;
    exp_busy_a = (qa != 0) && in_q(qa);
    exp_busy_b = (qb != 0) && in_q(qb);
    exp_regf = '0; exp_data = '0; do_pop = 0;
    if (r) begin
      exp_regf = '0;
    end else if (m_stall && mq.size() > 0) begin
      {exp_regf, exp_data} = mq[0]; do_pop = 1;
    end else if (pipe_regf != 0) begin
      exp_regf = pipe_regf; exp_data = pipe_data;
    end else if (mq.size() > 0) begin
      {exp_regf, exp_data} = mq[0]; do_pop = 1;
    end

    if (r) begin
      mq.delete(); m_age = 0; m_stall = 0;
    end else begin
      was_empty = (mq.size() == 0);
      if (do_pop) void'(mq.pop_front());
      if (lv && exp_ready && lr != 0) mq.push_back({lr, ld});
      if (was_empty || do_pop) m_age = 0;
      else if (m_age < STARVE) m_age++;
      if (mq.size() == 0) m_stall = 0;
      else if (m_age == STARVE) m_stall = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act_regf !== 5'd0) $display("FAIL reset_regf_during: got %0d expected 0", act_regf); else passed++;
    step(1, 3, 32'h5, 1, 4, 32'h6, 0, 0);
    total++; if (act_regf !== 5'd0) $display("FAIL reset_regf_during2: got %0d expected 0", act_regf); else passed++;
    step(0, 0, 0, 0, 0, 0, 7, 4);
    total++; if (act_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", act_count); else passed++;
    total++; if (act_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", act_ready); else passed++;
    total++; if (act_stall !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", act_stall); else passed++;
    total++; if (act_busy_a !== 1'b0 || act_busy_b !== 1'b0)
      $display("FAIL reset_busy: got %0b%0b expected 00", act_busy_a, act_busy_b); else passed++;
    total++; if (act_regf !== 5'd0) $display("FAIL reset_regf: got %0d expected 0", act_regf); else passed++;
  endtask

  task automatic test_pipe_only();
    step(0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    total++; if (act_regf !== 5'd5 || act_data !== 32'hDEADBEEF)
      $display("FAIL pipe_pass: got %0d/%h expected 5/deadbeef", act_regf, act_data); else passed++;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act_count !== 3'd0) $display("FAIL pipe_count: got %0d expected 0", act_count); else passed++;
    total++; if (act_regf !== 5'd0) $display("FAIL pipe_idle_regf: got %0d expected 0", act_regf); else passed++;
  endtask

  task automatic test_idle_drain();
    step(0, 0, 0, 1, 7, 32'h11, 7, 0);
    total++; if (act_busy_a !== 1'b0) $display("FAIL drain_push_invisible: got %0b expected 0", act_busy_a); else passed++;
    step(0, 0, 0, 0, 0, 0, 7, 0);
    total++; if (act_count !== 3'd1) $display("FAIL drain_count1: got %0d expected 1", act_count); else passed++;
    total++; if (act_busy_a !== 1'b1) $display("FAIL drain_busy_on_pop: got %0b expected 1", act_busy_a); else passed++;
    total++; if (act_regf !== 5'd7 || act_data !== 32'h11)
      $display("FAIL drain_write: got %0d/%h expected 7/11", act_regf, act_data); else passed++;
    step(0, 0, 0, 0, 0, 0, 7, 0);
    total++; if (act_count !== 3'd0) $display("FAIL drain_count0: got %0d expected 0", act_count); else passed++;
    total++; if (act_busy_a !== 1'b0) $display("FAIL drain_busy_clear: got %0b expected 0", act_busy_a); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      step(0, 5'(1 + i), 32'(i), 1, 5'(10 + i), 32'(32'hA0 + i), 0, 0);
    step(0, 1, 32'h99, 1, 20, 32'hBAD, 20, 13);
    total++; if (act_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", act_count); else passed++;
    total++; if (act_ready !== 1'b0) $display("FAIL full_ready: got %0b expected 0", act_ready); else passed++;
    total++; if (act_busy_b !== 1'b1) $display("FAIL full_busy_tail: got %0b expected 1", act_busy_b); else passed++;
    step(0, 2, 32'h98, 0, 0, 0, 20, 0);
    total++; if (act_count !== 3'd4) $display("FAIL full_no_accept: got %0d expected 4", act_count); else passed++;
    total++; if (act_busy_a !== 1'b0) $display("FAIL full_rejected_busy: got %0b expected 0", act_busy_a); else passed++;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (act_regf !== 5'(10 + k) || act_data !== 32'(32'hA0 + k))
        $display("FAIL full_drain_order: got %0d/%h expected %0d/%h", act_regf, act_data, 10 + k, 32'hA0 + k);
      else passed++;
    end
    idle(1);
  endtask

  task automatic test_starvation();
    int k;
    bit seen;
    step(0, 1, 32'h1, 1, 3, 32'h33, 0, 0);
    step(0, 1, 32'h2, 1, 4, 32'h44, 0, 0);
    seen = 0;
    for (k = 0; k < 20; k++) begin
      step(0, 2, 32'h3, 0, 0, 0, 0, 0);
      if (act_stall === 1'b1) begin seen = 1; break; end
    end
    total++; if (!seen || k != STARVE - 1)
      $display("FAIL starve_delay: got %0d (seen %0b) expected %0d", k, seen, STARVE - 1); else passed++;
    total++; if (act_regf !== 5'd3 || act_data !== 32'h33)
      $display("FAIL starve_pop1: got %0d/%h expected 3/33", act_regf, act_data); else passed++;
    step(0, 2, 32'h4, 0, 0, 0, 0, 0);
    total++; if (act_regf !== 5'd4 || act_stall !== 1'b1)
      $display("FAIL starve_pop2: got %0d stall %0b expected 4 stall 1", act_regf, act_stall); else passed++;
    step(0, 2, 32'h5, 0, 0, 0, 0, 0);
    total++; if (act_stall !== 1'b0 || act_count !== 3'd0)
      $display("FAIL starve_release: got stall %0b count %0d expected 0/0", act_stall, act_count); else passed++;
    total++; if (act_regf !== 5'd2) $display("FAIL starve_pipe_resume: got %0d expected 2", act_regf); else passed++;
  endtask

  task automatic test_edge();
    step(0, 0, 0, 1, 0, 32'h77, 0, 0);
    total++; if (act_ready !== 1'b1) $display("FAIL r0_ready: got %0b expected 1", act_ready); else passed++;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act_count !== 3'd0) $display("FAIL r0_count: got %0d expected 0", act_count); else passed++;
    total++; if (act_regf !== 5'd0) $display("FAIL r0_no_write: got %0d expected 0", act_regf); else passed++;
    step(0, 6, 32'h1, 1, 9, 32'h99, 0, 0);
    step(0, 6, 32'h2, 0, 0, 0, 0, 9);
    total++; if (act_busy_a !== 1'b0) $display("FAIL query_r0: got %0b expected 0", act_busy_a); else passed++;
    total++; if (act_busy_b !== 1'b1) $display("FAIL query_hit: got %0b expected 1", act_busy_b); else passed++;
    idle(2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 5'(21 + i), 32'(i), 0, 0);
    step(0, 1, 0, 0, 0, 0, 21, 0);
    total++; if (act_count !== 3'd3) $display("FAIL mid_count3: got %0d expected 3", act_count); else passed++;
    step(1, 6, 32'h66, 1, 25, 32'h55, 0, 0);
    total++; if (act_regf !== 5'd0) $display("FAIL mid_no_write: got %0d expected 0", act_regf); else passed++;
    step(0, 0, 0, 0, 0, 0, 21, 25);
    total++; if (act_count !== 3'd0 || act_stall !== 1'b0)
      $display("FAIL mid_cleared: got count %0d stall %0b expected 0/0", act_count, act_stall); else passed++;
    total++; if (act_regf !== 5'd0) $display("FAIL mid_no_stale: got %0d expected 0", act_regf); else passed++;
    total++; if (act_busy_a !== 1'b0 || act_busy_b !== 1'b0)
      $display("FAIL mid_busy: got %0b%0b expected 00", act_busy_a, act_busy_b); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic r;
      logic [4:0] pr, lr, qa, qb;
      r  = ($urandom_range(0, 99) == 0);
      pr = ($urandom_range(0, 99) < 55) ? 5'($urandom_range(1, 31)) : 5'd0;
      lr = 5'($urandom_range(0, 8));
      qa = 5'($urandom_range(0, 8));
      qb = 5'($urandom_range(0, 8));
      step(r, pr, $urandom, ($urandom_range(0, 99) < 45), lr, $urandom, qa, qb);
      total++; if (act_regf !== exp_regf) $display("FAIL rnd_regf c%0d: got %0d expected %0d", c, act_regf, exp_regf); else passed++;
      if (exp_regf != 0) begin
        total++; if (act_data !== exp_data) $display("FAIL rnd_data c%0d: got %h expected %h", c, act_data, exp_data); else passed++;
      end
      total++; if (act_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, act_ready, exp_ready); else passed++;
      total++; if (act_count !== exp_count) $display("FAIL rnd_count c%0d: got %0d expected %0d", c, act_count, exp_count); else passed++;
      total++; if (act_busy_a !== exp_busy_a) $display("FAIL rnd_busy_a c%0d: got %0b expected %0b", c, act_busy_a, exp_busy_a); else passed++;
      total++; if (act_busy_b !== exp_busy_b) $display("FAIL rnd_busy_b c%0d: got %0b expected %0b", c, act_busy_b, exp_busy_b); else passed++;
      total++; if (act_stall !== exp_stall) $display("FAIL rnd_stall c%0d: got %0b expected %0b", c, act_stall, exp_stall); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_idle_drain();
    test_full();
    test_starvation();
    test_edge();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
